// File: rtl/rf_mp.sv
// Multi-port register file: one write port, two registered read ports with write-first
// bypass, per-entry dirty bitmap and a one-entry-per-cycle clear engine reported via busy_o.
module rf_mp #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [ADDR_W-1:0]      wr_addr_i,
    input  logic [DATA_W-1:0]      wr_data_i,
    input  logic                   rd_en_a_i,
    input  logic [ADDR_W-1:0]      rd_addr_a_i,
    output logic [DATA_W-1:0]      rd_data_a_o,
    input  logic                   rd_en_b_i,
    input  logic [ADDR_W-1:0]      rd_addr_b_i,
    output logic [DATA_W-1:0]      rd_data_b_o,
    input  logic                   clr_req_i,
    output logic                   busy_o,
    output logic [(2**ADDR_W)-1:0] dirty_o
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd_a_q, rd_a_d;
    logic [DATA_W-1:0]   rd_b_q, rd_b_d;
    logic                busy_q, busy_d;
    logic [DEPTH-1:0]    dirty_q, dirty_d;
    logic                in_clear_s;

    // The file reads as RESET_VAL for the whole clear, even before each entry is wiped.
    function automatic logic [DATA_W-1:0] read_src(
        input logic              in_clear,
        input logic              bypass,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] entry
    );
        if (in_clear) begin
            return RESET_VAL;
        end else if (bypass) begin
            return wdata;
        end else begin
            return entry;
        end
    endfunction

    assign in_clear_s = (state_q == CLEAR);

    // Clear FSM, clear counter and dirty bitmap next-state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dirty_d = dirty_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                    dirty_d = {DEPTH{1'b0}};
                end else if (wr_en_i) begin
                    dirty_d[wr_addr_i] = 1'b1;
                end else begin
                    dirty_d = dirty_q;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                end else begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    // Read port next-state; each port holds when its strobe is low.
    always_comb begin
        rd_a_d = rd_a_q;
        rd_b_d = rd_b_q;
        if (rd_en_a_i) begin
            rd_a_d = read_src(in_clear_s, wr_en_i && (wr_addr_i == rd_addr_a_i),
                              wr_data_i, mem_q[rd_addr_a_i]);
        end else begin
            rd_a_d = rd_a_q;
        end
        if (rd_en_b_i) begin
            rd_b_d = read_src(in_clear_s, wr_en_i && (wr_addr_i == rd_addr_b_i),
                              wr_data_i, mem_q[rd_addr_b_i]);
        end else begin
            rd_b_d = rd_b_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
            busy_q  <= 1'b0;
            dirty_q <= {DEPTH{1'b0}};
            rd_a_q  <= {DATA_W{1'b0}};
            rd_b_q  <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            dirty_q <= dirty_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
        end
    end

    // Storage: clear engine owns the array while clearing, so writes are dropped then.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (in_clear_s) begin
            mem_q[cnt_q] <= RESET_VAL;
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_a_o = rd_a_q;
    assign rd_data_b_o = rd_b_q;
    assign busy_o      = busy_q;
    assign dirty_o     = dirty_q;

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: directed scenarios plus randomized traffic against a
// behavioural model that treats a clear as an instant logical wipe followed by 4 busy cycles.
module tb_rf_mp;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       wr_en_i = 1'b0;
    logic [1:0] wr_addr_i = 2'd0;
    logic [7:0] wr_data_i = 8'h00;
    logic       rd_en_a_i = 1'b0;
    logic [1:0] rd_addr_a_i = 2'd0;
    logic [7:0] rd_data_a_o;
    logic       rd_en_b_i = 1'b0;
    logic [1:0] rd_addr_b_i = 2'd0;
    logic [7:0] rd_data_b_o;
    logic       clr_req_i = 1'b0;
    logic       busy_o;
    logic [3:0] dirty_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_mem [4];
    logic [3:0] m_dirty;
    logic [7:0] m_ra, m_rb;
    int         m_left;

    rf_mp #(.DATA_W(8), .ADDR_W(2), .RESET_VAL(8'h00)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_en_a_i(rd_en_a_i), .rd_addr_a_i(rd_addr_a_i), .rd_data_a_o(rd_data_a_o),
        .rd_en_b_i(rd_en_b_i), .rd_addr_b_i(rd_addr_b_i), .rd_data_b_o(rd_data_b_o),
        .clr_req_i(clr_req_i), .busy_o(busy_o), .dirty_o(dirty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
        m_dirty = 4'b0000;
        m_ra    = 8'h00;
        m_rb    = 8'h00;
        m_left  = 0;
    endtask

    task automatic set_idle();
        wr_en_i   = 1'b0;
        rd_en_a_i = 1'b0;
        rd_en_b_i = 1'b0;
        clr_req_i = 1'b0;
    endtask

    // One clock edge; the model advances from the inputs held across the edge.
    task automatic cycle();
        logic       busy;
        logic [7:0] va, vb;
        busy = (m_left > 0);
        va = busy ? 8'h00 : ((wr_en_i && wr_addr_i == rd_addr_a_i) ? wr_data_i : m_mem[rd_addr_a_i]);
        vb = busy ? 8'h00 : ((wr_en_i && wr_addr_i == rd_addr_b_i) ? wr_data_i : m_mem[rd_addr_b_i]);
        @(posedge clk_i);
        #1;
        if (rd_en_a_i) m_ra = va;
        if (rd_en_b_i) m_rb = vb;
        if (busy) begin
            m_left--;
        end else if (clr_req_i) begin
            for (int i = 0; i < 4; i++) m_mem[i] = 8'h00;
            m_dirty = 4'b0000;
            m_left  = 4;
        end else if (wr_en_i) begin
            m_mem[wr_addr_i]   = wr_data_i;
            m_dirty[wr_addr_i] = 1'b1;
        end
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        set_idle();
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        cycle();
        set_idle();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        set_idle();
        model_reset();
        #12;
        @(negedge clk_i);
        rst_ni = 1'b1;
        rd_en_a_i = 1'b1; rd_addr_a_i = 2'd0;
        rd_en_b_i = 1'b1; rd_addr_b_i = 2'd3;
        cycle();
        set_idle();
        n_tests++;
        if (rd_data_a_o !== 8'h00) begin n_fail++; $display("FAIL reset_rd_a got=%h exp=00", rd_data_a_o); end
        n_tests++;
        if (rd_data_b_o !== 8'h00) begin n_fail++; $display("FAIL reset_rd_b got=%h exp=00", rd_data_b_o); end
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_tests++;
        if (dirty_o !== 4'b0000) begin n_fail++; $display("FAIL reset_dirty got=%b exp=0000", dirty_o); end
    endtask

    task automatic test_write_dual_read();
        write(2'd0, 8'hAA);
        write(2'd1, 8'hFF);
        rd_en_a_i = 1'b1; rd_addr_a_i = 2'd0;
        rd_en_b_i = 1'b1; rd_addr_b_i = 2'd1;
        cycle();
        set_idle();
        n_tests++;
        if (rd_data_a_o !== 8'hAA) begin n_fail++; $display("FAIL dual_rd_a got=%h exp=aa", rd_data_a_o); end
        n_tests++;
        if (rd_data_b_o !== 8'hFF) begin n_fail++; $display("FAIL dual_rd_b got=%h exp=ff", rd_data_b_o); end
        n_tests++;
        if (dirty_o !== 4'b0011) begin n_fail++; $display("FAIL dual_dirty got=%b exp=0011", dirty_o); end
        rd_addr_a_i = 2'd2; rd_addr_b_i = 2'd3;
        cycle();
        n_tests++;
        if (rd_data_a_o !== 8'hAA || rd_data_b_o !== 8'hFF) begin
            n_fail++; $display("FAIL hold_rd got=%h/%h exp=aa/ff", rd_data_a_o, rd_data_b_o);
        end
    endtask

    task automatic test_bypass();
        set_idle();
        wr_en_i = 1'b1; wr_addr_i = 2'd2; wr_data_i = 8'h5C;
        rd_en_a_i = 1'b1; rd_addr_a_i = 2'd2;
        rd_en_b_i = 1'b1; rd_addr_b_i = 2'd2;
        cycle();
        set_idle();
        n_tests++;
        if (rd_data_a_o !== 8'h5C) begin n_fail++; $display("FAIL bypass_a got=%h exp=5c", rd_data_a_o); end
        n_tests++;
        if (rd_data_b_o !== 8'h5C) begin n_fail++; $display("FAIL bypass_b got=%h exp=5c", rd_data_b_o); end
        rd_en_b_i = 1'b1; rd_addr_b_i = 2'd0;
        cycle();
        set_idle();
        n_tests++;
        if (rd_data_b_o !== 8'hAA) begin n_fail++; $display("FAIL post_bypass_b got=%h exp=aa", rd_data_b_o); end
    endtask

    task automatic test_clear();
        int busy_cnt;
        for (int i = 0; i < 4; i++) write(2'(i), 8'(8'h11 * (i + 1)));
        clr_req_i = 1'b1;
        cycle();
        set_idle();
        busy_cnt = 0;
        n_tests++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL clr_busy_rise got=%b exp=1", busy_o); end
        n_tests++;
        if (dirty_o !== 4'b0000) begin n_fail++; $display("FAIL clr_dirty got=%b exp=0000", dirty_o); end
        if (busy_o === 1'b1) busy_cnt = 1;
        for (int k = 0; k < 10; k++) begin
            if (busy_o !== 1'b1) break;
            set_idle();
            rd_en_a_i = 1'b1;
            rd_addr_a_i = (k == 0) ? 2'd1 : 2'(k);
            if (k == 0) begin wr_en_i = 1'b1; wr_addr_i = 2'd1; wr_data_i = 8'h99; end
            if (k == 1) clr_req_i = 1'b1;
            cycle();
            set_idle();
            n_tests++;
            if (rd_data_a_o !== 8'h00) begin n_fail++; $display("FAIL clr_busy_read k=%0d got=%h exp=00", k, rd_data_a_o); end
            if (busy_o === 1'b1) busy_cnt++;
        end
        n_tests++;
        if (busy_cnt != 4) begin n_fail++; $display("FAIL clr_busy_len got=%0d exp=4", busy_cnt); end
        for (int i = 0; i < 4; i++) begin
            rd_en_a_i = 1'b1; rd_addr_a_i = 2'(i);
            cycle();
            set_idle();
            n_tests++;
            if (rd_data_a_o !== 8'h00) begin n_fail++; $display("FAIL clr_after addr=%0d got=%h exp=00", i, rd_data_a_o); end
        end
        n_tests++;
        if (dirty_o !== 4'b0000 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL clr_end dirty=%b busy=%b exp=0000/0", dirty_o, busy_o);
        end
    endtask

    task automatic test_write_and_clear();
        write(2'd0, 8'h21);
        wr_en_i = 1'b1; wr_addr_i = 2'd3; wr_data_i = 8'h7E; clr_req_i = 1'b1;
        cycle();
        set_idle();
        n_tests++;
        if (dirty_o !== 4'b0000) begin n_fail++; $display("FAIL wrclr_dirty got=%b exp=0000", dirty_o); end
        for (int k = 0; k < 6 && busy_o === 1'b1; k++) cycle();
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL wrclr_busy_timeout got=%b exp=0", busy_o); end
        rd_en_a_i = 1'b1; rd_addr_a_i = 2'd3;
        rd_en_b_i = 1'b1; rd_addr_b_i = 2'd0;
        cycle();
        set_idle();
        n_tests++;
        if (rd_data_a_o !== 8'h00 || rd_data_b_o !== 8'h00) begin
            n_fail++; $display("FAIL wrclr_read got=%h/%h exp=00/00", rd_data_a_o, rd_data_b_o);
        end
    endtask

    task automatic test_reset_mid_clear();
        write(2'd2, 8'h55);
        write(2'd3, 8'h66);
        clr_req_i = 1'b1;
        cycle();
        set_idle();
        cycle();
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midclr_busy got=%b exp=0", busy_o); end
        n_tests++;
        if (dirty_o !== 4'b0000 || rd_data_a_o !== 8'h00) begin
            n_fail++; $display("FAIL midclr_state dirty=%b rd_a=%h exp=0000/00", dirty_o, rd_data_a_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        write(2'd0, 8'h12);
        for (int i = 0; i < 4; i++) begin
            rd_en_a_i = 1'b1; rd_addr_a_i = 2'(i);
            cycle();
            set_idle();
            n_tests++;
            if (rd_data_a_o !== ((i == 0) ? 8'h12 : 8'h00)) begin
                n_fail++; $display("FAIL midclr_read addr=%0d got=%h exp=%h", i, rd_data_a_o, (i == 0) ? 8'h12 : 8'h00);
            end
            n_tests++;
            if (busy_o !== 1'b0) begin n_fail++; $display("FAIL midclr_residual_busy got=%b exp=0", busy_o); end
        end
        n_tests++;
        if (dirty_o !== 4'b0001) begin n_fail++; $display("FAIL midclr_dirty got=%b exp=0001", dirty_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en_i     = 1'($urandom_range(0, 1));
            wr_addr_i   = 2'($urandom_range(0, 3));
            wr_data_i   = 8'($urandom);
            rd_en_a_i   = 1'($urandom_range(0, 1));
            rd_addr_a_i = 2'($urandom_range(0, 3));
            rd_en_b_i   = 1'($urandom_range(0, 1));
            rd_addr_b_i = ($urandom_range(0, 3) == 0) ? rd_addr_a_i : 2'($urandom_range(0, 3));
            clr_req_i   = ($urandom_range(0, 19) == 0);
            cycle();
            n_tests++;
            if (rd_data_a_o !== m_ra || rd_data_b_o !== m_rb) begin
                n_fail++; $display("FAIL rand_rd n=%0d got=%h/%h exp=%h/%h", n, rd_data_a_o, rd_data_b_o, m_ra, m_rb);
            end
            n_tests++;
            if (busy_o !== (m_left > 0) || dirty_o !== m_dirty) begin
                n_fail++; $display("FAIL rand_ctl n=%0d busy=%b dirty=%b exp=%b/%b", n, busy_o, dirty_o, m_left > 0, m_dirty);
            end
        end
        set_idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_dual_read();
        test_bypass();
        test_clear();
        test_write_and_clear();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_mp.md
# rf_mp

Parametrised multi-port register file, the next generation of the single-port RF in the datapath. One synchronous write port and two independent registered read ports (A, B) let the ALU fetch two operands per cycle. Write-to-read bypass and a per-entry dirty bitmap are built in. A sequential clear engine wipes the file one entry per cycle under a BUSY handshake, so the controller can reset register state without pulsing the global reset.

## Interface
- DATA_W, default 8, width of each entry.
- ADDR_W, default 2, address width; DEPTH = 2**ADDR_W entries.
- RESET_VAL, default 0, value loaded into every entry by reset and by clear; DATA_W bits.

- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-low reset.
- WR_EN  in  1  write strobe.
- WR_ADDR  in  ADDR_W  write address.
- WR_DATA  in  DATA_W  write data.
- RD_EN_A  in  1  read strobe, port A.
- RD_ADDR_A  in  ADDR_W  read address, port A.
- RD_DATA_A  out  DATA_W  registered read data, port A.
- RD_EN_B  in  1  read strobe, port B.
- RD_ADDR_B  in  ADDR_W  read address, port B.
- RD_DATA_B  out  DATA_W  registered read data, port B.
- CLR_REQ  in  1  single-cycle request to clear the whole file.
- BUSY  out  1  clear in progress; registered.
- DIRTY  out  DEPTH  bit i set when entry i was written since the last reset or clear; registered.

## Operation
- Reset (RST=0, asynchronous):
  - all entries = RESET_VAL;
  - RD_DATA_A = RD_DATA_B = 0;
  - BUSY = 0, DIRTY = 0;
  - FSM = IDLE, clear counter = 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on a rising edge with CLR_REQ=1.
  - CLEAR -> IDLE on the edge where the counter equals DEPTH-1.
  - CLR_REQ sampled in CLEAR is ignored; it is not queued.
- Write, IDLE only: on an edge with WR_EN=1 and state IDLE, mem[WR_ADDR] <= WR_DATA and DIRTY[WR_ADDR] <= 1. WR_EN in CLEAR is dropped; no entry changes and DIRTY is unchanged.
- Clear engine:
  - On the IDLE->CLEAR edge, DIRTY <= 0 (all bits) and the counter is set to 0.
  - Each CLEAR cycle writes mem[counter] <= RESET_VAL, then increments the counter.
  - The counter is ADDR_W bits and wraps naturally after DEPTH-1.
- Read, per port independently:
  - On an edge with RD_EN_x=1, RD_DATA_x is loaded.
  - With RD_EN_x=0, RD_DATA_x holds its value.
- Read data source, in priority order:
  - state CLEAR: RESET_VAL, because the file is logically cleared from the start of CLEAR;
  - WR_EN=1 and WR_ADDR==RD_ADDR_x in IDLE: WR_DATA (write-first bypass);
  - otherwise: mem[RD_ADDR_x].
- Both ports may read the same address in the same cycle, and both receive identical data.
- Simultaneous WR_EN and CLR_REQ in IDLE:
  - the write to mem lands;
  - DIRTY clear takes priority, so DIRTY = 0 after the edge;
  - the entry is wiped during CLEAR.

## Timing
- Read latency: 1 cycle. Address presented before edge N gives data valid after edge N.
- Write latency: 1 cycle. A non-bypassed read of the same address at edge N+1 returns the new value.
- BUSY:
  - rises after the edge sampling CLR_REQ;
  - stays high for exactly DEPTH cycles;
  - falls after the edge that clears entry DEPTH-1.
- The first write accepted after a clear is on the edge at which BUSY is sampled 0.
- Reset asserted mid-CLEAR aborts immediately:
  - all entries = RESET_VAL, BUSY = 0, FSM = IDLE;
  - no residual clear continues after release.
- DIRTY updates on the same edge as the write that causes it.

## Test plan
All scenarios use DATA_W=8, ADDR_W=2, RESET_VAL=0.
- Reset then read -> after RST released, read A addr 0 and B addr 3: RD_DATA_A = RD_DATA_B = 0x00, BUSY=0, DIRTY=4'b0000.
- Write then dual read -> write 0xAA to addr 0, then 0xFF to addr 1, then read A=0 and B=1 in the same cycle: next cycle RD_DATA_A=0xAA, RD_DATA_B=0xFF, DIRTY=4'b0011. With RD_EN_x=0 the outputs hold.
- Bypass -> WR_EN=1, addr 2, 0x5C in the same cycle as RD_EN_A=1, RD_ADDR_A=2: RD_DATA_A=0x5C after that edge.
- Clear sequence -> fill all 4 entries with 0x11..0x44, pulse CLR_REQ:
  - BUSY is high for exactly 4 cycles and DIRTY=0 from the first BUSY cycle;
  - a WR_EN of 0x99 to addr 1 during BUSY is dropped;
  - a CLR_REQ during BUSY does not extend it;
  - reads during BUSY return 0x00, and all entries read 0x00 afterwards.
- Simultaneous write and clear -> WR_EN to addr 3 with 0x7E together with CLR_REQ: DIRTY=0 after the edge, and addr 3 reads 0x00 after BUSY falls.
- Reset mid-clear -> assert RST during the 2nd BUSY cycle: BUSY=0 immediately, all entries 0x00. After release, a write of 0x12 to addr 0 reads back 0x12 and BUSY stays 0.
